// File: rtl/lbp_stream.sv
// Streaming 3x3 LBP engine: reads a gray image once in raster order and writes one
// 8-bit code per interior pixel, using two line buffers and a two-column window.
module lbp_stream #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_CENTER = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);
  localparam logic [ADDR_W-1:0] CENTER_OFS  = ADDR_W'(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic                gray_req_q, gray_req_d;
  logic [ADDR_W-1:0]   gray_addr_q, gray_addr_d;
  logic                drain_q, drain_d;
  logic                cap_q, cap_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   win_q [2][3];
  logic [DATA_W-1:0]   win_d [2][3];
  logic [DATA_W-1:0]   lb_top_q [IMG_W];
  logic [DATA_W-1:0]   lb_mid_q [IMG_W];
  logic                lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0]   lbp_addr_q, lbp_addr_d;
  logic [7:0]          lbp_data_q, lbp_data_d;
  logic                finish_q, finish_d;

  logic [DATA_W-1:0]   new_top, new_mid, ctr;
  logic [7:0]          code;
  logic                emit;

  // Window is [column][row]: column 0 = c-2, column 1 = c-1, the arriving column c
  // comes straight from the line buffers and gray_data.
  always_comb begin
    new_top = lb_top_q[col_q];
    new_mid = lb_mid_q[col_q];
    ctr     = win_q[1][1];
    code[0] = win_q[0][0] >= ctr;
    code[1] = win_q[1][0] >= ctr;
    code[2] = new_top     >= ctr;
    code[3] = win_q[0][1] >= ctr;
    code[4] = new_mid     >= ctr;
    code[5] = win_q[0][2] >= ctr;
    code[6] = win_q[1][2] >= ctr;
    code[7] = gray_data   >= ctr;
  end

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    gray_req_d  = 1'b0;
    gray_addr_d = gray_addr_q;
    drain_d     = drain_q;
    cap_d       = gray_req_q;
    win_d       = win_q;
    row_d       = row_q;
    col_d       = col_q;
    cap_addr_d  = cap_addr_q;
    emit        = cap_q && (row_q >= RW'(2)) && (col_q >= CW'(2));
    lbp_valid_d = emit;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q | (lbp_valid_q && (lbp_addr_q == LAST_CENTER));

    case (state_q)
      IDLE: if (gray_ready) state_d = FETCH;
      FETCH: begin
        if (gray_ready) begin
          gray_req_d  = 1'b1;
          gray_addr_d = fetch_cnt_q;
          fetch_cnt_d = fetch_cnt_q + ADDR_W'(1);
          if (fetch_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      default: state_d = DONE;
    endcase

    if (cap_q) begin
      for (int i = 0; i < 3; i++) win_d[0][i] = win_q[1][i];
      win_d[1][0] = new_top;
      win_d[1][1] = new_mid;
      win_d[1][2] = gray_data;
      cap_addr_d  = cap_addr_q + ADDR_W'(1);
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (emit) begin
      lbp_addr_d = cap_addr_q - CENTER_OFS;
      lbp_data_d = code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_cnt_q <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      drain_q     <= 1'b0;
      cap_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      cap_addr_q  <= '0;
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 3; r++) win_q[c][r] <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      drain_q     <= drain_d;
      cap_q       <= cap_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cap_addr_q  <= cap_addr_d;
      win_q       <= win_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  // Row r-2 shifts out as row r-1 moves up and the arriving pixel takes its place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb_top_q[i] <= '0;
        lb_mid_q[i] <= '0;
      end
    end else if (cap_q) begin
      lb_top_q[col_q] <= new_mid;
      lb_mid_q[col_q] <= gray_data;
    end
  end

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_stream.sv
// Bench for lbp_stream: full 128x128 frames against a scoreboard, plus small-image
// instances driven from a table of hand-computed neighbourhood codes.
`timescale 1ns/1ps
module tb_lbp_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-size instance
  logic        a_ready = 1'b0, a_req, a_valid, a_finish;
  logic [13:0] a_addr, a_laddr;
  logic [7:0]  a_data = '0, a_ldata;
  // 5x4 instance
  logic        b_ready = 1'b0, b_req, b_valid, b_finish;
  logic [4:0]  b_addr, b_laddr;
  logic [7:0]  b_data = '0, b_ldata;
  // 3x3 instance with 10-bit pixels
  logic        c_ready = 1'b0, c_req, c_valid, c_finish;
  logic [3:0]  c_addr, c_laddr;
  logic [9:0]  c_data = '0;
  logic [7:0]  c_ldata;

  lbp_stream dut_a (
    .clk(clk), .reset(reset), .gray_ready(a_ready), .gray_req(a_req), .gray_addr(a_addr),
    .gray_data(a_data), .lbp_valid(a_valid), .lbp_addr(a_laddr), .lbp_data(a_ldata),
    .finish(a_finish));

  lbp_stream #(.IMG_W(5), .IMG_H(4), .ADDR_W(5), .DATA_W(8)) dut_b (
    .clk(clk), .reset(reset), .gray_ready(b_ready), .gray_req(b_req), .gray_addr(b_addr),
    .gray_data(b_data), .lbp_valid(b_valid), .lbp_addr(b_laddr), .lbp_data(b_ldata),
    .finish(b_finish));

  lbp_stream #(.IMG_W(3), .IMG_H(3), .ADDR_W(4), .DATA_W(10)) dut_c (
    .clk(clk), .reset(reset), .gray_ready(c_ready), .gray_req(c_req), .gray_addr(c_addr),
    .gray_data(c_data), .lbp_valid(c_valid), .lbp_addr(c_laddr), .lbp_data(c_ldata),
    .finish(c_finish));

  logic [7:0]  img_a [16384];
  int          a_fetch_cyc [16384];
  logic [21:0] exp_q [$];
  logic [7:0]  img_b [20];
  logic [9:0]  img_c [9];
  logic [4:0]  b_addrs [6];

  typedef struct {
    logic [7:0] nb [9];
    logic [7:0] exp_code;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_a(input int r, input int c);
    logic [7:0] p;
    p = img_a[r*128 + c];
    return {img_a[(r+1)*128 + c+1] >= p, img_a[(r+1)*128 + c] >= p,
            img_a[(r+1)*128 + c-1] >= p, img_a[r*128 + c+1] >= p,
            img_a[r*128 + c-1] >= p,     img_a[(r-1)*128 + c+1] >= p,
            img_a[(r-1)*128 + c] >= p,   img_a[(r-1)*128 + c-1] >= p};
  endfunction

  task automatic build_exp_a();
    logic [13:0] ad;
    exp_q.delete();
    for (int r = 1; r < 127; r++)
      for (int c = 1; c < 127; c++) begin
        ad = 14'(r*128 + c);
        exp_q.push_back({ad, ref_a(r, c)});
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic a_frame(input int drop0, input int drop1, input int rst_at);
    int cyc, fetches, pulses, drop_left, last_cyc, fin_cyc, idx;
    bit pend, aborted;
    logic [13:0] pend_addr, prev_addr, next_addr;
    logic [21:0] e;
    cyc = 0; fetches = 0; pulses = 0; drop_left = 0; last_cyc = -10; fin_cyc = -1;
    pend = 1'b0; aborted = 1'b0; pend_addr = '0; prev_addr = '0; next_addr = '0;
    a_ready = 1'b1;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pend) a_data = img_a[pend_addr];
      pend = a_req;
      pend_addr = a_addr;
      if (!a_ready) begin
        check("pause_req", a_req, 0);
        check("pause_addr", a_addr, prev_addr);
      end else if (a_req) begin
        check("fetch_addr", a_addr, next_addr);
        a_fetch_cyc[a_addr] = cyc;
        next_addr++;
        fetches++;
      end
      if (a_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", a_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("lbp_addr", a_laddr, e[21:8]);
          check($sformatf("lbp_data@%0d", e[21:8]), a_ldata, e[7:0]);
          idx = int'(a_laddr) + 129;
          if (idx < 16384) check("latency", 64'(cyc - a_fetch_cyc[idx]), 2);
        end
        if (a_laddr == 14'd16254) last_cyc = cyc;
      end
      if (a_finish && fin_cyc < 0) begin
        fin_cyc = cyc;
        check("finish_timing", cyc, last_cyc + 1);
      end else if (fin_cyc >= 0) begin
        check("finish_sticky", a_finish, 1);
        check("quiet_valid", a_valid, 0);
        check("quiet_req", a_req, 0);
      end
      prev_addr = a_addr;
      if (rst_at >= 0 && a_req && int'(a_addr) == rst_at) begin
        #1 reset = 1'b1;
        #1;
        check("rst_gray_req", a_req, 0);
        check("rst_gray_addr", a_addr, 0);
        check("rst_lbp_valid", a_valid, 0);
        check("rst_lbp_addr", a_laddr, 0);
        check("rst_lbp_data", a_ldata, 0);
        check("rst_finish", a_finish, 0);
        aborted = 1'b1;
        break;
      end
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) a_ready = 1'b1;
      end else if (a_req && (int'(a_addr) == drop0 || int'(a_addr) == drop1)) begin
        a_ready = 1'b0;
        drop_left = 5;
      end
      if (fin_cyc >= 0 && cyc >= fin_cyc + 4) break;
    end
    if (aborted) begin
      @(negedge clk);
      reset = 1'b0;
    end else begin
      check("finish_seen", fin_cyc >= 0, 1);
      check("pulse_count", pulses, 15876);
      check("queue_left", exp_q.size(), 0);
      check("fetch_count", fetches, 16384);
    end
  endtask

  task automatic b_run(input int k);
    int cyc, pulses, fin;
    bit pend;
    logic [4:0] pend_addr;
    for (int i = 0; i < 20; i++) img_b[i] = 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) img_b[r*5 + c] = vecs[k].nb[r*3 + c];
    do_reset();
    b_ready = 1'b1;
    cyc = 0; pulses = 0; fin = -1; pend = 1'b0; pend_addr = '0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pend) b_data = img_b[pend_addr];
      pend = b_req;
      pend_addr = b_addr;
      if (b_valid) begin
        if (pulses < 6) check($sformatf("b_addr[%0d]", k), b_laddr, b_addrs[pulses]);
        if (pulses == 0) check($sformatf("b_code[%0d]", k), b_ldata, vecs[k].exp_code);
        pulses++;
      end
      if (b_finish && fin < 0) fin = cyc;
      if (fin >= 0 && cyc >= fin + 3) break;
    end
    check($sformatf("b_count[%0d]", k), pulses, 6);
    check($sformatf("b_finish[%0d]", k), fin >= 0, 1);
  endtask

  task automatic c_run();
    int cyc, pulses, fin;
    bit pend;
    logic [3:0] pend_addr;
    img_c = '{10'd0, 10'd299, 10'd0, 10'd0, 10'd300, 10'd300, 10'd0, 10'd0, 10'd0};
    do_reset();
    c_ready = 1'b1;
    cyc = 0; pulses = 0; fin = -1; pend = 1'b0; pend_addr = '0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (pend) c_data = img_c[pend_addr];
      pend = c_req;
      pend_addr = c_addr;
      if (c_valid) begin
        pulses++;
        check("c_addr", c_laddr, 4);
        check("c_code", c_ldata, 8'h10);
      end
      if (c_finish && fin < 0) fin = cyc;
      if (fin >= 0 && cyc >= fin + 3) break;
    end
    check("c_count", pulses, 1);
    check("c_finish", fin >= 0, 1);
  endtask

  initial begin
    b_addrs = '{5'd6, 5'd7, 5'd8, 5'd11, 5'd12, 5'd13};
    vecs[0] = '{nb: '{8'd100, 8'd99, 8'd101, 8'd50, 8'd100, 8'd200, 8'd100, 8'd150, 8'd0}, exp_code: 8'h75};
    vecs[1] = '{nb: '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7}, exp_code: 8'hFF};
    vecs[2] = '{nb: '{8'd10, 8'd10, 8'd10, 8'd10, 8'd255, 8'd10, 8'd10, 8'd10, 8'd10}, exp_code: 8'h00};
    vecs[3] = '{nb: '{8'd128, 8'd127, 8'd127, 8'd127, 8'd128, 8'd127, 8'd127, 8'd127, 8'd127}, exp_code: 8'h01};
    vecs[4] = '{nb: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd200}, exp_code: 8'h80};
    vecs[5] = '{nb: '{8'd0, 8'd255, 8'd0, 8'd255, 8'd128, 8'd255, 8'd0, 8'd255, 8'd0}, exp_code: 8'h5A};
    vecs[6] = '{nb: '{8'd49, 8'd49, 8'd51, 8'd49, 8'd50, 8'd49, 8'd49, 8'd49, 8'd49}, exp_code: 8'h04};
    vecs[7] = '{nb: '{8'd49, 8'd49, 8'd49, 8'd49, 8'd50, 8'd49, 8'd51, 8'd49, 8'd49}, exp_code: 8'h20};

    @(negedge clk);
    check("init_gray_req", a_req, 0);
    check("init_gray_addr", a_addr, 0);
    check("init_lbp_valid", a_valid, 0);
    check("init_lbp_addr", a_laddr, 0);
    check("init_lbp_data", a_ldata, 0);
    check("init_finish", a_finish, 0);
    check("init_b_finish", b_finish, 0);
    check("init_c_valid", c_valid, 0);

    // constant image: every interior code is all-ones
    for (int i = 0; i < 16384; i++) img_a[i] = 8'h55;
    do_reset();
    build_exp_a();
    a_frame(-1, -1, -1);

    // low-entropy random image, two 5-cycle source pauses
    for (int i = 0; i < 16384; i++) img_a[i] = 8'($urandom_range(0, 15));
    do_reset();
    build_exp_a();
    a_frame(300, 8000, -1);

    // full-range random image, reset mid-frame, then a complete re-run
    for (int i = 0; i < 16384; i++) img_a[i] = 8'($urandom_range(0, 255));
    do_reset();
    build_exp_a();
    a_frame(-1, -1, 5000);
    build_exp_a();
    a_frame(-1, -1, -1);

    for (int k = 0; k < 8; k++) b_run(k);
    c_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
